// File: rtl/cram_save_dma.sv
// Cartridge-RAM save DMA: dumps cart RAM to a host stream or loads it back, stealing RAM cycles when ce_cpu=0.
// Optional macro CRAM_DMA_CHECKSUM_EN adds a 16-bit running byte sum on the checksum output.
module cram_save_dma (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_cpu,
  input  logic [16:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  input  logic [1:0]  ram_mask,
  input  logic        dump_req,
  input  logic        load_req,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [16:0] ram_addr,
  output logic        ram_wr,
  output logic [7:0]  ram_do,
  input  logic [7:0]  ram_di,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum,
  output logic [2:0]  state_dbg
);

  // Handshakes: a byte moves on out_valid&out_ready or in_valid&in_ready in the same
  // clk_sys cycle; valid/data hold steady until accepted, ready never depends on valid.
  typedef enum logic [2:0] {
    S_IDLE,
    S_DP_ADDR,
    S_DP_WAIT,
    S_DP_OUT,
    S_LD_IN,
    S_LD_COMMIT,
    S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [16:0] ptr_q, ptr_d;
  logic [16:0] last_q, last_d;
  logic [7:0]  byte_q, byte_d;
  logic        dma_wr;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    byte_d  = byte_q;
    dma_wr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dump_req || load_req) begin
          ptr_d   = '0;
          // Last index (mask+1)*8192-1 is just the mask above thirteen ones.
          last_d  = {2'b00, ram_mask, 13'h1FFF};
          state_d = dump_req ? S_DP_ADDR : S_LD_IN;
        end
      end
      S_DP_ADDR: begin
        if (!ce_cpu) state_d = S_DP_WAIT;
      end
      S_DP_WAIT: begin
        // DP_ADDR only exits on a DMA-owned cycle, so ram_di here is always our byte.
        byte_d  = ram_di;
        state_d = S_DP_OUT;
      end
      S_DP_OUT: begin
        if (out_ready) begin
          if (ptr_q == last_q) begin
            state_d = S_FINISH;
          end else begin
            ptr_d   = ptr_q + 17'd1;
            state_d = S_DP_ADDR;
          end
        end
      end
      S_LD_IN: begin
        if (in_valid) begin
          byte_d  = in_data;
          state_d = S_LD_COMMIT;
        end
      end
      S_LD_COMMIT: begin
        if (!ce_cpu) begin
          dma_wr = 1'b1;
          if (ptr_q == last_q) begin
            state_d = S_FINISH;
          end else begin
            ptr_d   = ptr_q + 17'd1;
            state_d = S_LD_IN;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_data  = byte_q;
  assign out_valid = (state_q == S_DP_OUT);
  assign in_ready  = (state_q == S_LD_IN);
  assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done      = (state_q == S_FINISH);
  assign state_dbg = state_q;

  // The CPU owns the RAM port whenever ce_cpu is high, whatever the FSM is doing.
  assign ram_addr = ce_cpu ? cpu_addr : ptr_q;
  assign ram_wr   = ce_cpu ? cpu_wr   : dma_wr;
  assign ram_do   = ce_cpu ? cpu_di   : byte_q;

`ifdef CRAM_DMA_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
  logic        xfer_start;
  logic        byte_hs;
  logic [7:0]  hs_byte;

  always_comb begin
    xfer_start = (state_q == S_IDLE) && (dump_req || load_req);
    byte_hs    = (out_valid && out_ready) || (in_ready && in_valid);
    hs_byte    = out_valid ? byte_q : in_data;
    csum_d     = csum_q;
    if (xfer_start) begin
      csum_d = '0;
    end else if (byte_hs) begin
      csum_d = csum_q + {8'h00, hs_byte};
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_cram_save_dma.sv
// Bench for cram_save_dma: simulated cart RAM, CPU port driver, transfer-level model and per-cycle checker.
module tb_cram_save_dma;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce_cpu;
  logic [16:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [1:0]  ram_mask;
  logic        dump_req, load_req;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [16:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_do, ram_di;
  logic        busy, done;
  logic [15:0] checksum;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  cram_save_dma dut (
    .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu), .cpu_addr(cpu_addr),
    .cpu_wr(cpu_wr), .cpu_di(cpu_di), .ram_mask(ram_mask), .dump_req(dump_req),
    .load_req(load_req), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_do(ram_do),
    .ram_di(ram_di), .busy(busy), .done(done), .checksum(checksum),
    .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cart RAM: preloaded with addr[7:0], synchronous write, one-cycle read latency.
  logic [7:0] mem [0:131071];
  initial begin
    for (int a = 0; a < 131072; a++) mem[a] = a[7:0];
    ram_di = 8'h00;
    forever begin
      @(posedge clk_sys);
      if (ram_wr) mem[ram_addr] <= ram_do;
      ram_di <= mem[ram_addr];
    end
  end

  // CPU port driver: optionally toggles ce_cpu, issuing one write of 0x5A to 0x0100.
  bit tog_en = 0;
  bit cpu_wrote = 0;
  initial begin
    ce_cpu = 0; cpu_addr = '0; cpu_wr = 0; cpu_di = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (tog_en) begin
        ce_cpu = ~ce_cpu;
        if (ce_cpu && !cpu_wrote) begin
          cpu_addr = 17'h00100; cpu_wr = 1; cpu_di = 8'h5A; cpu_wrote = 1;
        end else if (ce_cpu) begin
          cpu_addr = 17'($urandom_range(0, 131071));
          cpu_wr = 0;
          cpu_di = 8'($urandom_range(0, 255));
        end else begin
          cpu_wr = 0;
        end
      end else begin
        ce_cpu = 0; cpu_wr = 0;
      end
    end
  end

  // Transfer model: mode 0 idle, 1 dump, 2 load.
  int          m_mode = 0;
  int          m_idx = 0;
  int          m_len = 0;
  logic [15:0] m_sum = '0;
  bit          m_end = 0;
  logic [7:0]  exp_q[$];
  int          done_cnt = 0;
  int          load_wr_total = 0;
  bit          pv = 0;
  logic [7:0]  pd = '0;

  function automatic logic [7:0] dump_byte(input int a);
    logic [31:0] av;
    av = a;
    if (cpu_wrote && a == 256) return 8'h5A;
    return av[7:0];
  endfunction

  function automatic logic [15:0] exp_csum();
`ifdef CRAM_DMA_CHECKSUM_EN
    return m_sum;
`else
    return 16'h0000;
`endif
  endfunction

  always @(negedge clk_sys) begin
    bit was_idle;
    if (done) done_cnt++;
    if (reset) begin
      m_mode = 0; m_end = 0; exp_q.delete(); pv = 0;
    end else begin
      was_idle = (m_mode == 0);
      if (m_end) begin
        check("done_pulse", done, 1);
        check("busy_in_finish", busy, 0);
        check("checksum_at_done", checksum, exp_csum());
        m_mode = 0; m_end = 0;
      end else begin
        check("done_quiet", done, 0);
        check("busy", busy, m_mode != 0);
      end
      check("valid_ready_exclusive", out_valid && in_ready, 0);
      if (m_mode != 1) check("out_valid_outside_dump", out_valid, 0);
      if (m_mode != 2) check("in_ready_outside_load", in_ready, 0);
      if (ce_cpu) begin
        check("mux_addr", ram_addr, cpu_addr);
        check("mux_wr", ram_wr, cpu_wr);
        check("mux_do", ram_do, cpu_di);
      end
`ifndef CRAM_DMA_CHECKSUM_EN
      check("checksum_zero", checksum, 0);
`endif
      if (pv) begin
        check("out_valid_held", out_valid, 1);
        check("out_data_held", out_data, pd);
      end
      if (m_mode == 1 && out_valid && out_ready) begin
        check("dump_byte", out_data, dump_byte(m_idx));
        m_sum = m_sum + {8'h00, dump_byte(m_idx)};
        m_idx++;
        if (m_idx == m_len) m_end = 1;
      end
      pv = out_valid && !out_ready;
      pd = out_data;
      if (m_mode == 2 && in_valid && in_ready) begin
        exp_q.push_back(in_data);
        m_sum = m_sum + {8'h00, in_data};
      end
      if (!ce_cpu && ram_wr) begin
        check("dma_wr_mode", m_mode, 2);
        check("dma_wr_pending", exp_q.size() != 0, 1);
        if (m_mode == 2 && exp_q.size() != 0) begin
          check("dma_wr_addr", ram_addr, m_idx);
          check("dma_wr_data", ram_do, exp_q.pop_front());
          m_idx++;
          load_wr_total++;
          if (m_idx == m_len) m_end = 1;
        end
      end
      if (was_idle && (dump_req || load_req)) begin
        m_mode = dump_req ? 1 : 2;
        m_idx = 0; m_sum = '0; m_end = 0;
        m_len = (int'(ram_mask) + 1) * 8192;
      end
    end
  end

  task automatic pulse(input logic d, input logic l);
    @(posedge clk_sys); #1;
    dump_req = d; load_req = l;
    @(posedge clk_sys); #1;
    dump_req = 0; load_req = 0;
  endtask

  task automatic wait_idx(input int n, input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk_sys);
      if (m_idx >= n) break;
    end
    check(name, m_idx >= n, 1);
  endtask

  task automatic wait_done(input int start_cnt, input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk_sys);
      if (done_cnt > start_cnt) break;
    end
    check(name, done_cnt > start_cnt, 1);
  endtask

  task automatic reset_checks();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_checksum", checksum, 16'h0000);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_ram_addr", ram_addr, 17'h00000);
  endtask

  initial begin
    int t0, d0;
    reset = 1; dump_req = 0; load_req = 0; ram_mask = 2'd0; out_ready = 1;
    in_data = 8'hA5; in_valid = 0;
    #1;
    reset_checks();
    repeat (3) @(posedge clk_sys);
    #1 reset = 0;

    // Full 8 KiB dump; simultaneous load_req loses, later load_req and mask change ignored.
    d0 = done_cnt;
    t0 = cyc;
    pulse(1, 1);
    @(negedge clk_sys);
    check("t1_busy_after_req", busy, 1);
    check("t1_not_loading", in_ready, 0);
    wait_idx(1000, 5000, "t1_progress_timeout");
    ram_mask = 2'd3;
    pulse(0, 1);
    wait_done(d0, 30000, "t1_done_timeout");
    check("t1_throughput", (cyc - t0) <= 3 * 8192 + 4, 1);
    check("t1_model_count", m_idx, 8192);
    check("t1_model_sum", m_sum, 16'hF000);
    check("t1_checksum", checksum, exp_csum());
    repeat (20) @(posedge clk_sys);
    check("t1_single_done", done_cnt - d0, 1);
    check("t1_idle_busy", busy, 0);
    ram_mask = 2'd0;

    // Dump while the CPU takes every other cycle and writes 0x5A to 0x0100; abort at byte 300.
    tog_en = 1;
    d0 = done_cnt;
    pulse(1, 0);
    wait_idx(300, 4000, "t2_progress_timeout");
    @(posedge clk_sys); #3;
    reset = 1;
    tog_en = 0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 0;
    check("t2_cpu_write_landed", mem[256], 8'h5A);
    repeat (5) @(posedge clk_sys);
    check("t2_no_done", done_cnt - d0, 0);

    // Backpressure for 50 cycles at byte 5, then reset at byte 100.
    d0 = done_cnt;
    pulse(1, 0);
    wait_idx(5, 200, "t3_progress_timeout");
    #1 out_ready = 0;
    repeat (50) @(posedge clk_sys);
    @(negedge clk_sys);
    check("t3_bp_valid", out_valid, 1);
    check("t3_bp_data", out_data, 8'h05);
    check("t3_bp_index", m_idx, 5);
    @(posedge clk_sys); #1 out_ready = 1;
    wait_idx(100, 1000, "t3_progress2_timeout");
    #3 reset = 1;
    #1;
    reset_checks();
    repeat (3) @(posedge clk_sys);
    #1 reset = 0;
    repeat (5) @(posedge clk_sys);
    check("t3_no_done", done_cnt - d0, 0);

    // 16 KiB load of 0xA5 with the host always valid.
    ram_mask = 2'd1;
    in_valid = 1;
    d0 = done_cnt;
    load_wr_total = 0;
    t0 = cyc;
    pulse(0, 1);
    wait_done(d0, 40000, "t4_done_timeout");
    check("t4_throughput", (cyc - t0) <= 2 * 16384 + 4, 1);
    check("t4_model_count", m_idx, 16384);
    check("t4_wr_pulses", load_wr_total, 16384);
    check("t4_model_sum", m_sum, 16'h4000);
    check("t4_checksum", checksum, exp_csum());
    check("t4_last_byte", mem[16383], 8'hA5);
    check("t4_untouched", mem[16384], 8'h00);
    in_valid = 0;
    repeat (10) @(posedge clk_sys);
    check("t4_single_done", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
